// File: rtl/alu4_pkg.sv
// alu4_pkg: op codes and sequencer state encoding shared by the alu4 block family
package alu4_pkg;
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_NOT = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_LT  = 3'd6;
  localparam logic [2:0] OP_EQ  = 3'd7;
  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;
endpackage

// File: rtl/edge_pulse.sv
// edge_pulse: one-cycle pulse on a rising edge of an already-synchronised level
module edge_pulse (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_pulse
);
  logic r_q;
  always_ff @(posedge clk)
    r_q <= rst ? 1'b0 : i_d;
  assign o_pulse = i_d & ~r_q;
endmodule

// File: rtl/alu4_seq_ctrl.sv
// alu4_seq_ctrl: button-driven sequencer for the alu4 ALU (manual single op or auto-scan of all ops)
module alu4_seq_ctrl
  import alu4_pkg::*;
#(
  parameter  int DWELL = 1_000_000,
  localparam int CNT_W = $clog2(DWELL + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn,
  input  logic       mode,
  input  logic [2:0] sw_sel,
  input  logic [3:0] sw_a,
  input  logic [3:0] sw_b,
  input  logic [3:0] alu_c,
  input  logic       alu_s,
  output logic [2:0] alu_sel,
  output logic       alu_en,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [3:0] res,
  output logic       res_s,
  output logic       res_stb,
  output logic       busy,
  output logic       done,
  input  logic [2:0] rd_idx,
  output logic [4:0] rd_data
);
  state_t           r_state;
  logic             r_run_mode;
  logic [3:0]       r_a, r_b;
  logic [2:0]       r_sel;
  logic [CNT_W-1:0] r_cnt;
  logic [4:0]       r_hist [8];
  logic             w_press;
  edge_pulse u_edge (.clk(clk), .rst(rst), .i_d(btn), .o_pulse(w_press));
  assign alu_a   = r_a;
  assign alu_b   = r_b;
  assign alu_sel = r_sel;
  assign alu_en  = r_state == EXEC;
  assign busy    = r_state != IDLE;
  assign rd_data = r_hist[rd_idx];
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_run_mode <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_sel      <= '0;
      r_cnt      <= '0;
      r_hist     <= '{default: '0};
      res        <= '0;
      res_s      <= 1'b0;
      res_stb    <= 1'b0;
      done       <= 1'b0;
    end else begin
      res_stb <= 1'b0;
      done    <= 1'b0;
      case (r_state)
        IDLE: if (w_press) begin
          r_a        <= sw_a;
          r_b        <= sw_b;
          r_sel      <= mode ? OP_ADD : sw_sel;
          r_run_mode <= mode;
          r_state    <= EXEC;
        end
        EXEC: begin
          res            <= alu_c;
          res_s          <= alu_s;
          r_hist[r_sel]  <= {alu_s, alu_c};
          res_stb        <= 1'b1;
          r_cnt          <= CNT_W'(DWELL - 1);
          r_state        <= r_run_mode ? HOLD : IDLE;
          done           <= ~r_run_mode;
        end
        HOLD: begin
          // a press during the dwell aborts the scan and is consumed
          if (w_press) r_state <= IDLE;
          else if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
          else if (r_sel == OP_EQ) begin
            r_state <= IDLE;
            done    <= 1'b1;
          end else begin
            r_sel   <= r_sel + 3'd1;
            r_state <= EXEC;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/alu4_seq_ctrl.md
Name: alu4_seq_ctrl

Overview:
Sequencer that drives the shared 4-bit signed ALU (alu4) from board switches/button.
- Manual mode: one button press latches operands and runs a single op.
- Auto-scan mode: one press runs all 8 ALU ops back-to-back, dwelling on each so the 7-seg display can show it.
- Results are captured into a registered result port and an 8-entry history buffer indexed by op code, for display muxing upstream of the bcd7seg/s7seg decoders.

Parameters:
DWELL, 1_000_000, cycles each result is held in auto-scan before the next op (must be >= 1).
CNT_W, $clog2(DWELL+1), dwell counter width (derived; do not override).

Ports:
clk  in  1  system clock
rst  in  1  reset; one clock, synchronous, active-high
btn  in  1  raw level from board button, already synchronised to clk
mode  in  1  0 = manual single op, 1 = auto-scan ops 0..7
sw_sel  in  3  op code used in manual mode
sw_a  in  4  operand A (signed)
sw_b  in  4  operand B (signed)
alu_c  in  4  ALU result C
alu_s  in  1  ALU status flag s
alu_sel  out  3  op code to ALU
alu_en  out  1  ALU enable
alu_a  out  4  operand A to ALU
alu_b  out  4  operand B to ALU
res  out  4  last captured result
res_s  out  1  last captured flag
res_stb  out  1  one-cycle pulse when res/res_s are updated
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse at end of a manual op or a completed scan
rd_idx  in  3  history read index
rd_data  out  5  {s, C} stored for op rd_idx (combinational read)

Behaviour:
- Reset values: state=IDLE; all outputs 0; operand regs 0; cur_sel 0; history all 0; btn_q 0. Reset mid-operation aborts immediately, with no done pulse.
- Edge detect: btn_q <= btn every cycle. press = btn & ~btn_q. Only one op sequence per press; holding btn does nothing further.
- alu_a/alu_b are the latched operand regs, alu_sel = cur_sel, alu_en = 1 only in EXEC.
- States:
  - IDLE: on press, latch op_a<=sw_a, op_b<=sw_b, cur_sel <= mode ? 0 : sw_sel, latch mode into run_mode, then go to EXEC. sw_* changes after the latch are ignored.
  - EXEC (1 cycle): at the end of the cycle, capture res<=alu_c, res_s<=alu_s, hist[cur_sel]<={alu_s,alu_c}, and pulse res_stb on the next cycle.
    - run_mode=0: go to IDLE and pulse done.
    - run_mode=1: load cnt<=DWELL-1 and go to HOLD.
  - HOLD: cnt decrements each cycle. When cnt==0:
    - cur_sel==7: go to IDLE and pulse done.
    - otherwise: cur_sel<=cur_sel+1 and go to EXEC.
    - A press while in HOLD aborts to IDLE with no done pulse; that press is consumed and does not start a new run.
- Latency:
  - Manual: press edge to res_stb = 2 cycles.
  - Auto scan: total = 8 EXEC + 7*DWELL (first) + DWELL (last) cycles. Op k is captured DWELL+1 cycles after op k-1.
- A press in EXEC is ignored.
- res holds its value until the next capture. History persists across runs and is overwritten per op code.
- No arithmetic is done here; the signed interpretation belongs to the ALU. cur_sel wraps nowhere, because the scan ends at 7.

Decomposition:
- Shared package alu4_pkg: op-code constants OP_ADD=0, OP_SUB=1, OP_NOT=2, OP_AND=3, OP_OR=4, OP_XOR=5, OP_LT=6, OP_EQ=7; state encoding enum (IDLE, EXEC, HOLD).
- One sub-module is natural: edge_pulse (btn -> press rising-edge detector). FSM, counter and the 8x5 history register file stay in the top.

Test Plan:
- Reset mid-HOLD (DWELL=3, auto run at op 2) -> next cycle busy=0, res=0, rd_data=0 for all idx, no done pulse.
- Manual: mode=0, sw_sel=OP_ADD, A=3, B=2, press -> alu_en high for 1 cycle, res=4'b0101, res_stb 2 cycles after press, done pulse, hist[0]=5'b00101.
- Manual SUB: A=3, B=5 -> res=4'b1110 (-2), with res_s matching the alu4 model. Then hold btn high 20 cycles -> exactly one op executed.
- Auto (DWELL=3): A=4'b0110, B=4'b0011, press -> alu_sel steps 0..7 and res_stb fires 8 times spaced 4 cycles apart. Then done, busy low, and hist[3] (AND)=5'b00010, hist[5] (XOR)=5'b00101.
- Abort: auto run, second press during HOLD of op 4 -> IDLE next cycle, no done, hist[5..7] unchanged from the prior run. Changing sw_a mid-scan never alters alu_a.
